// File: rtl/multiword_addsub_seq.sv
// Sequential multi-word two's-complement adder/subtractor: one WIDTH-bit lane per cycle,
// LSB lane first, with the inter-lane carry held in a register.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RUN   | one lane added per cycle, carry chained through a register
// DONE  | one-cycle done pulse; res/cout/overflow valid from here
module multiword_addsub_seq #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   add_n,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] res,
    output logic                   cout,
    output logic                   overflow
);

    localparam int N     = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             sub_q;
    logic [IDX_W-1:0] idx;
    logic             carry;

    logic [WIDTH-1:0] a_lane;
    logic [WIDTH-1:0] b_lane;
    logic [WIDTH-1:0] bl;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             last;

    always_comb begin
        a_lane = '0;
        b_lane = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                a_lane = a_q[i*WIDTH +: WIDTH];
                b_lane = b_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Subtract is a + ~b + 1; the +1 enters as the initial carry loaded on start.
    assign bl       = b_lane ^ {WIDTH{sub_q}};
    assign {c, r}   = {1'b0, a_lane} + {1'b0, bl} + {{WIDTH{1'b0}}, carry};
    assign last     = (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            res      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= add_n;
                        idx   <= '0;
                        carry <= add_n;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx == IDX_W'(i)) res[i*WIDTH +: WIDTH] <= r;
                    end
                    carry <= c;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout     <= c;
                        // Signed overflow uses the effective B so it holds for add and subtract.
                        overflow <= (a_lane[WIDTH-1] == bl[WIDTH-1]) &&
                                    (r[WIDTH-1] != a_lane[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
